// File: rtl/des_decrypt_key_schedule.sv
// DES round-subkey generator for the decryption pipeline: one key in, K16..K1 out.
// Optional encrypt ordering (K1..K16) is enabled by defining DES_KSCHED_BIDIR_EN.
module des_decrypt_key_schedule #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DES_KSCHED_BIDIR_EN
  input  logic        mode,
`endif
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey_out,
  output logic [3:0]  subkey_round,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [4:0]  round_q, round_d;
`ifdef DES_KSCHED_BIDIR_EN
  logic        mode_q, mode_d;
`endif

  logic [27:0] pc1_c;
  logic [27:0] pc1_d;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic        run;
  logic        is_last;
  logic        key_parity_unused;
  logic        cd_unused;

  // Single-bit shift for rounds 1, 2, 9 and 16; two bits for every other round.
  function automatic logic shift_two(input logic [4:0] r);
    return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

`ifdef DES_KSCHED_BIDIR_EN
  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction
`endif

  // PC-1 with DES bit n at key_in[64-n]; parity bits 8,16,..,64 never appear.
  assign pc1_c = {key_in[7],  key_in[15], key_in[23], key_in[31],
                  key_in[39], key_in[47], key_in[55], key_in[63],
                  key_in[6],  key_in[14], key_in[22], key_in[30],
                  key_in[38], key_in[46], key_in[54], key_in[62],
                  key_in[5],  key_in[13], key_in[21], key_in[29],
                  key_in[37], key_in[45], key_in[53], key_in[61],
                  key_in[4],  key_in[12], key_in[20], key_in[28]};
  assign pc1_d = {key_in[1],  key_in[9],  key_in[17], key_in[25],
                  key_in[33], key_in[41], key_in[49], key_in[57],
                  key_in[2],  key_in[10], key_in[18], key_in[26],
                  key_in[34], key_in[42], key_in[50], key_in[58],
                  key_in[3],  key_in[11], key_in[19], key_in[27],
                  key_in[35], key_in[43], key_in[51], key_in[59],
                  key_in[36], key_in[44], key_in[52], key_in[60]};
  assign key_parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                               key_in[24], key_in[16], key_in[8],  key_in[0]};

  // PC-2 on the concatenated C||D, DES bit n of CD at cd[56-n].
  assign cd = {c_q, d_q};
  assign pc2_out = {cd[42], cd[39], cd[45], cd[32], cd[55], cd[51],
                    cd[53], cd[28], cd[41], cd[50], cd[35], cd[46],
                    cd[33], cd[37], cd[44], cd[52], cd[30], cd[48],
                    cd[40], cd[49], cd[29], cd[36], cd[43], cd[54],
                    cd[15], cd[4],  cd[25], cd[19], cd[9],  cd[1],
                    cd[26], cd[16], cd[5],  cd[11], cd[23], cd[8],
                    cd[12], cd[7],  cd[17], cd[0],  cd[22], cd[3],
                    cd[10], cd[14], cd[6],  cd[20], cd[27], cd[24]};
  assign cd_unused = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

  assign run = (state_q == RUN);

`ifdef DES_KSCHED_BIDIR_EN
  assign is_last = mode_q ? (round_q == 5'd1) : (round_q == LAST_ROUND);
`else
  assign is_last = (round_q == 5'd1);
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
`ifdef DES_KSCHED_BIDIR_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = RUN;
          c_d     = pc1_c;
          d_d     = pc1_d;
          round_d = LAST_ROUND;
`ifdef DES_KSCHED_BIDIR_EN
          mode_d  = mode;
          // Encrypt ordering presents K1 first, so pre-apply round 1's shift.
          if (!mode) begin
            c_d     = rotl28(pc1_c, 1'b0);
            d_d     = rotl28(pc1_d, 1'b0);
            round_d = 5'd1;
          end
`endif
        end
      end
      RUN: begin
        if (subkey_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
`ifdef DES_KSCHED_BIDIR_EN
            if (mode_q) begin
              c_d     = rotr28(c_q, shift_two(round_q));
              d_d     = rotr28(d_q, shift_two(round_q));
              round_d = round_q - 5'd1;
            end else begin
              c_d     = rotl28(c_q, shift_two(round_q + 5'd1));
              d_d     = rotl28(d_q, shift_two(round_q + 5'd1));
              round_d = round_q + 5'd1;
            end
`else
            c_d     = rotr28(c_q, shift_two(round_q));
            d_d     = rotr28(d_q, shift_two(round_q));
            round_d = round_q - 5'd1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
`ifdef DES_KSCHED_BIDIR_EN
      mode_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
`ifdef DES_KSCHED_BIDIR_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign key_ready    = !run;
  assign subkey_valid = run;
  assign subkey_out   = run ? pc2_out : '0;
  assign subkey_round = run ? 4'(round_q - 5'd1) : '0;
  assign subkey_last  = run && is_last;

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Directed bench for des_decrypt_key_schedule with a textbook forward key-schedule model.
module tb_des_decrypt_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [47:0] subkey_out;
  logic [3:0]  subkey_round;
  logic        subkey_last;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
`ifdef DES_KSCHED_BIDIR_EN
  logic        mode = 1'b1;
`endif

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  des_decrypt_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DES_KSCHED_BIDIR_EN
    .mode         (mode),
`endif
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey_out   (subkey_out),
    .subkey_round (subkey_round),
    .subkey_last  (subkey_last),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] k;
    logic [3:0]  rnd;
    logic        last;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  int key_acc_cnt = 0;
  int beat_cnt    = 0;
  int cyc         = 0;
  int acc_cyc[$];
  beat_t exp_q[$];
  logic [47:0] got_q[$];
  logic [47:0] ref_q[$];
  logic [47:0] model_k[$];

  int pc1_t[$] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                   10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                   63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                   14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t[$] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                   23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                   41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                   44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shift_t[$] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void bound_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endfunction

  // Bit n (1-based, MSB first) of a src_w-wide source is (src >> (src_w-n)) & 1.
  function automatic logic [63:0] permute(input logic [63:0] src, input int src_w, input int tbl[$]);
    logic [63:0] r;
    r = '0;
    foreach (tbl[i]) r = (r << 1) | ((src >> (src_w - tbl[i])) & 64'd1);
    return r;
  endfunction

  function automatic logic [63:0] rotl28(input logic [63:0] v, input int s);
    return ((v << s) | (v >> (28 - s))) & 64'hFFFFFFF;
  endfunction

  // Standard forward schedule: model_k[r-1] holds Kr.
  function automatic void compute_schedule(input logic [63:0] key);
    logic [63:0] cd0, c, d, sk;
    model_k.delete();
    cd0 = permute(key, 64, pc1_t);
    c = (cd0 >> 28) & 64'hFFFFFFF;
    d = cd0 & 64'hFFFFFFF;
    for (int r = 0; r < 16; r++) begin
      c = rotl28(c, shift_t[r]);
      d = rotl28(d, shift_t[r]);
      sk = permute((c << 28) | d, 56, pc2_t);
      model_k.push_back(sk[47:0]);
    end
  endfunction

  function automatic void push_expected(input logic decrypt);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = decrypt ? (16 - i) : (i + 1);
      b.k    = model_k[r - 1];
      b.rnd  = 4'(r - 1);
      b.last = decrypt ? (r == 1) : (r == 16);
      exp_q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    logic dec;
    cyc++;
    chk("key_ready", {63'd0, key_ready}, {63'd0, exp_q.size() == 0});
    chk("subkey_valid", {63'd0, subkey_valid}, {63'd0, exp_q.size() != 0});
    if (subkey_valid && exp_q.size() != 0) begin
      chk("subkey_out", {16'd0, subkey_out}, {16'd0, exp_q[0].k});
      chk("subkey_round", {60'd0, subkey_round}, {60'd0, exp_q[0].rnd});
      chk("subkey_last", {63'd0, subkey_last}, {63'd0, exp_q[0].last});
    end
    if (rst) begin
      exp_q.delete();
    end else begin
      if (subkey_valid && subkey_ready && exp_q.size() != 0) begin
        got_q.push_back(subkey_out);
        void'(exp_q.pop_front());
        beat_cnt++;
      end
      if (key_valid && key_ready) begin
        dec = 1'b1;
`ifdef DES_KSCHED_BIDIR_EN
        dec = mode;
`endif
        compute_schedule(key_in);
        push_expected(dec);
        key_acc_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit bp, input string nm);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      subkey_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      guard++;
    end
    subkey_ready = 1'b1;
    if (guard >= 400) bound_fail(nm);
  endtask

  task automatic run_key(input logic [63:0] k, input bit bp, input string nm);
    int start_acc, guard;
    got_q.delete();
    start_acc = key_acc_cnt;
    key_in = k;
    key_valid = 1'b1;
    subkey_ready = 1'b1;
    guard = 0;
    while (key_acc_cnt == start_acc && guard < 50) begin
      step();
      guard++;
    end
    key_valid = 1'b0;
    if (key_acc_cnt == start_acc) bound_fail({nm, "_accept"});
    drain(bp, nm);
  endtask

  task automatic cmp_ref(input string nm);
    chk({nm, "_count"}, 64'(got_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size()) chk(nm, {16'd0, got_q[i]}, {16'd0, ref_q[i]});
    end
  endtask

  initial begin
    int start_beats, guard;

    compute_schedule(KEY_A);
    chk("model_k1", {16'd0, model_k[0]}, 64'h1B02EFFC7072);
    chk("model_k2", {16'd0, model_k[1]}, 64'h79AED9DBC9E5);
    chk("model_k16", {16'd0, model_k[15]}, 64'hCB3D8B0E17F5);

    repeat (3) step();
    chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
    chk("rst_subkey_valid", {63'd0, subkey_valid}, 64'd0);
    chk("rst_subkey_last", {63'd0, subkey_last}, 64'd0);
    chk("rst_subkey_round", {60'd0, subkey_round}, 64'd0);
    chk("rst_subkey_out", {16'd0, subkey_out}, 64'd0);
    rst = 1'b0;
    step();

    // Basic decrypt order with literal pins on K16, K2, K1.
    run_key(KEY_A, 1'b0, "basic");
    chk("basic_count", 64'(got_q.size()), 64'd16);
    if (got_q.size() == 16) begin
      chk("basic_k16", {16'd0, got_q[0]}, 64'hCB3D8B0E17F5);
      chk("basic_k2", {16'd0, got_q[14]}, 64'h79AED9DBC9E5);
      chk("basic_k1", {16'd0, got_q[15]}, 64'h1B02EFFC7072);
    end
    ref_q = got_q;
    chk("basic_key_ready_after", {63'd0, key_ready}, 64'd1);

    // Random backpressure.
    run_key(KEY_A, 1'b1, "backpressure");
    cmp_ref("backpressure_stream");

    // Second key held valid during the whole first sequence.
    got_q.delete();
    acc_cyc.delete();
    key_in = KEY_A;
    key_valid = 1'b1;
    subkey_ready = 1'b1;
    guard = 0;
    while (acc_cyc.size() < 1 && guard < 50) begin step(); guard++; end
    key_in = KEY_B;
    guard = 0;
    while (acc_cyc.size() < 2 && guard < 100) begin step(); guard++; end
    key_valid = 1'b0;
    if (acc_cyc.size() < 2) bound_fail("key_during_run_accept");
    else chk("key_during_run_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd17);
    drain(1'b0, "key_during_run");
    got_q = got_q[0:15];
    cmp_ref("key_during_run_first");

    // Reset after the 5th accepted beat.
    got_q.delete();
    start_beats = beat_cnt;
    key_in = KEY_A;
    key_valid = 1'b1;
    subkey_ready = 1'b1;
    guard = 0;
    while (beat_cnt < start_beats + 5 && guard < 60) begin
      step();
      if (key_ready == 1'b0) key_valid = 1'b0;
      guard++;
    end
    key_valid = 1'b0;
    if (beat_cnt < start_beats + 5) bound_fail("midreset_beats");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_valid", {63'd0, subkey_valid}, 64'd0);
    chk("midreset_key_ready", {63'd0, key_ready}, 64'd1);
    run_key(KEY_A, 1'b0, "after_reset");
    if (got_q.size() > 0) chk("after_reset_k16", {16'd0, got_q[0]}, 64'hCB3D8B0E17F5);
    else bound_fail("after_reset_k16");

    // Parity bits inverted must not matter.
    run_key(KEY_A ^ 64'h0101010101010101, 1'b1, "parity");
    cmp_ref("parity_stream");

`ifdef DES_KSCHED_BIDIR_EN
    mode = 1'b0;
    run_key(KEY_A, 1'b0, "encrypt");
    mode = 1'b1;
    chk("enc_count", 64'(got_q.size()), 64'd16);
    if (got_q.size() == 16) begin
      chk("enc_first_k1", {16'd0, got_q[0]}, 64'h1B02EFFC7072);
      chk("enc_last_k16", {16'd0, got_q[15]}, 64'hCB3D8B0E17F5);
    end
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
